// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester-side bus of the data-memory arbiter.
// master: the two requesters (port 0 = CPU load/store, port 1 = loader/debug)
//   drive req/we/addr/wd and receive ack/rdata plus the shared err/busy.
// slave: the arbiter, which answers each request with a one-cycle ack.
interface dmem_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              req0, we0, ack0;
  logic [DATA_W-1:0] addr0, wd0, rdata0;
  logic              req1, we1, ack1;
  logic [DATA_W-1:0] addr1, wd1, rdata1;
  logic              err, busy;
  modport master (
    output req0, we0, addr0, wd0, req1, we1, addr1, wd1,
    input  ack0, rdata0, ack1, rdata1, err, busy
  );
  modport slave (
    input  req0, we0, addr0, wd0, req1, we1, addr1, wd1,
    output ack0, rdata0, ack1, rdata1, err, busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing one single-port data memory between two requesters.
// Ports: clk, reset (async, active low); bus (requester handshake, slave side);
//   mem_we/mem_a/mem_wd/mem_rd to a memory with posedge write and combinational read;
//   cnt0/cnt1 saturating counts of completed accesses per port.
// Every access is IDLE (sample) -> ACCESS (memory cycle) -> RESP (ack pulse).
module dmem_arbiter #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  dmem_arbiter_if.slave     bus,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_nx;
  logic              last_grant, gid, we_q, grant, in_range;
  logic [DATA_W-1:0] addr_q, wd_q, rd0_q, rd1_q;
  // On a tie the port that was not served last wins; otherwise whoever asks.
  assign grant    = (bus.req0 && bus.req1) ? !last_grant : bus.req1;
  assign in_range = addr_q < DATA_W'(DEPTH);
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  // mem_we decodes the state register directly so an asynchronous reset
  // during ACCESS kills the write before the next edge.
  always_comb begin
    state_nx = state == IDLE ? ((bus.req0 || bus.req1) ? ACCESS : IDLE)
             : state == ACCESS ? RESP : IDLE;
    mem_we   = state == ACCESS && we_q && in_range;
    mem_a    = state == ACCESS ? addr_q : '0;
    mem_wd   = state == ACCESS ? wd_q : '0;
  end
  assign bus.ack0   = state == RESP && !gid;
  assign bus.ack1   = state == RESP && gid;
  assign bus.err    = state == RESP && !in_range;
  assign bus.busy   = state != IDLE;
  assign bus.rdata0 = rd0_q;
  assign bus.rdata1 = rd1_q;
  // The per-port read registers are loaded at the end of ACCESS, so a store
  // returns the pre-write word and the idle port's rdata keeps its old value.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      last_grant <= 1'b1;
      gid        <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wd_q       <= '0;
      rd0_q      <= '0;
      rd1_q      <= '0;
      cnt0       <= '0;
      cnt1       <= '0;
    end else begin
      if (state == IDLE && (bus.req0 || bus.req1)) begin
        gid        <= grant;
        last_grant <= grant;
        we_q       <= grant ? bus.we1 : bus.we0;
        addr_q     <= grant ? bus.addr1 : bus.addr0;
        wd_q       <= grant ? bus.wd1 : bus.wd0;
      end
      if (state == ACCESS && !gid) rd0_q <= in_range ? mem_rd : '0;
      if (state == ACCESS && gid) rd1_q <= in_range ? mem_rd : '0;
      if (state == RESP && !gid && !(&cnt0)) cnt0 <= cnt0 + CNT_W'(1);
      if (state == RESP && gid && !(&cnt1)) cnt1 <= cnt1 + CNT_W'(1);
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table-driven and scoreboard checks of dmem_arbiter against a behavioural memory.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.DATA_W(32)) bus ();
  logic        mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;
  logic [15:0] cnt0, cnt1;
  dmem_arbiter dut (
    .clk(clk), .reset(reset), .bus(bus), .mem_we(mem_we), .mem_a(mem_a),
    .mem_wd(mem_wd), .mem_rd(mem_rd), .cnt0(cnt0), .cnt1(cnt1)
  );

  // Second instance with 2-bit counters to reach saturation quickly.
  dmem_arbiter_if #(.DATA_W(32)) bus2 ();
  logic        mem_we2;
  logic [31:0] mem_a2, mem_wd2;
  logic [31:0] mem_rd2 = 32'h0;
  logic [1:0]  sc0, sc1;
  dmem_arbiter #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2), .mem_we(mem_we2), .mem_a(mem_a2),
    .mem_wd(mem_wd2), .mem_rd(mem_rd2), .cnt0(sc0), .cnt1(sc1)
  );

  logic [31:0] mem [64];
  always @(posedge clk) if (mem_we) mem[mem_a[5:0]] <= mem_wd;
  assign mem_rd = mem[mem_a[5:0]];

  int total = 0;
  int passed = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  typedef struct {bit port; bit err; bit chk_rd; logic [31:0] rd;} exp_t;
  exp_t sbq[$];

  // Scoreboard: every ack pops the oldest expected response.
  always @(negedge clk) begin
    if (bus.ack0 && bus.ack1) chk("ack_overlap", 32'd1, 32'd0);
    else if (bus.ack0 || bus.ack1) begin
      if (sbq.size() == 0) chk("unexpected_ack", {31'd0, bus.ack1}, 32'hFFFF_FFFF);
      else begin
        exp_t e;
        e = sbq.pop_front();
        chk("ack_port", {31'd0, bus.ack1}, {31'd0, e.port});
        chk("err", {31'd0, bus.err}, {31'd0, e.err});
        if (e.chk_rd) chk("rdata", e.port ? bus.rdata1 : bus.rdata0, e.rd);
      end
    end
  end

  typedef struct {bit port; bit we; logic [31:0] addr; logic [31:0] wd; bit chk_rd; logic [31:0] rd;} vec_t;
  vec_t tbl[12];

  task automatic do_access(input vec_t v);
    int n;
    bit oor;
    exp_t e;
    oor = v.addr >= 32'd64;
    e.port = v.port; e.err = oor; e.chk_rd = v.chk_rd; e.rd = oor ? 32'h0 : v.rd;
    sbq.push_back(e);
    @(posedge clk); #1;
    if (v.port) begin bus.req1 = 1; bus.we1 = v.we; bus.addr1 = v.addr; bus.wd1 = v.wd; end
    else begin bus.req0 = 1; bus.we0 = v.we; bus.addr0 = v.addr; bus.wd0 = v.wd; end
    @(negedge clk);
    n = 0;
    while (!(bus.ack0 || bus.ack1) && n < 10) begin
      if (n == 1) begin
        chk("mem_we", {31'd0, mem_we}, {31'd0, v.we && !oor});
        chk("mem_a", mem_a, v.addr);
        chk("mem_wd", mem_wd, v.wd);
      end
      @(negedge clk);
      n++;
    end
    chk("latency", n, 2);
    @(posedge clk); #1;
    bus.req0 = 0; bus.req1 = 0;
  endtask

  initial begin
    int e0, e1;
    exp_t e;
    bus.req0 = 0; bus.we0 = 0; bus.addr0 = 0; bus.wd0 = 0;
    bus.req1 = 0; bus.we1 = 0; bus.addr1 = 0; bus.wd1 = 0;
    bus2.req0 = 0; bus2.we0 = 0; bus2.addr0 = 0; bus2.wd0 = 0;
    bus2.req1 = 0; bus2.we1 = 0; bus2.addr1 = 5; bus2.wd1 = 0;
    tbl[0]  = '{0, 1, 32'd4,  32'd161,        0, 32'd0};
    tbl[1]  = '{1, 0, 32'd4,  32'd0,          1, 32'd161};
    tbl[2]  = '{1, 1, 32'd3,  32'd90,         0, 32'd0};
    tbl[3]  = '{0, 1, 32'd3,  32'd3,          1, 32'd90};
    tbl[4]  = '{0, 0, 32'd3,  32'd0,          1, 32'd3};
    tbl[5]  = '{0, 1, 32'd0,  32'h1234_5678,  0, 32'd0};
    tbl[6]  = '{1, 1, 32'd64, 32'hDEAD_BEEF,  1, 32'd0};
    tbl[7]  = '{1, 0, 32'd0,  32'd0,          1, 32'h1234_5678};
    tbl[8]  = '{1, 1, 32'd63, 32'hA5A5_A5A5,  0, 32'd0};
    tbl[9]  = '{0, 0, 32'd63, 32'd0,          1, 32'hA5A5_A5A5};
    tbl[10] = '{0, 0, 32'hFFFF_FFFF, 32'd0,   1, 32'd0};
    tbl[11] = '{1, 1, 32'd8,  32'h88,         0, 32'd0};
    #2 reset = 0;
    @(negedge clk); @(negedge clk);
    chk("rst_ack0", {31'd0, bus.ack0}, 0);
    chk("rst_ack1", {31'd0, bus.ack1}, 0);
    chk("rst_err", {31'd0, bus.err}, 0);
    chk("rst_busy", {31'd0, bus.busy}, 0);
    chk("rst_mem_we", {31'd0, mem_we}, 0);
    chk("rst_mem_a", mem_a, 0);
    chk("rst_rdata0", bus.rdata0, 0);
    chk("rst_cnt1", {16'd0, cnt1}, 0);
    // Both ports request continuously from reset: grants 0,1,0,1.
    @(posedge clk); #1;
    reset = 1;
    bus.req0 = 1; bus.addr0 = 100; bus.req1 = 1; bus.addr1 = 200;
    e.err = 1; e.chk_rd = 1; e.rd = 0;
    for (int i = 0; i < 4; i++) begin e.port = i[0]; sbq.push_back(e); end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk($sformatf("tie_ack0_c%0d", c), {31'd0, bus.ack0}, {31'd0, c == 2 || c == 8});
      chk($sformatf("tie_ack1_c%0d", c), {31'd0, bus.ack1}, {31'd0, c == 5 || c == 11});
    end
    @(posedge clk); #1;
    bus.req0 = 0; bus.req1 = 0;
    @(negedge clk);
    chk("tie_cnt0", {16'd0, cnt0}, 2);
    chk("tie_cnt1", {16'd0, cnt1}, 2);
    e0 = 2; e1 = 2;
    foreach (tbl[i]) begin
      do_access(tbl[i]);
      if (tbl[i].port) e1++; else e0++;
    end
    @(negedge clk);
    chk("cnt0", {16'd0, cnt0}, e0);
    chk("cnt1", {16'd0, cnt1}, e1);
    // Reset during the ACCESS cycle of a store to word 8.
    @(posedge clk); #1;
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 8; bus.wd0 = 32'h55;
    @(negedge clk); @(negedge clk);
    chk("mid_mem_we_pre", {31'd0, mem_we}, 1);
    #2 reset = 0;
    #1;
    chk("mid_mem_we", {31'd0, mem_we}, 0);
    chk("mid_busy", {31'd0, bus.busy}, 0);
    chk("mid_mem_a", mem_a, 0);
    chk("mid_mem_wd", mem_wd, 0);
    chk("mid_rdata1", bus.rdata1, 0);
    chk("mid_cnt0", {16'd0, cnt0}, 0);
    bus.req0 = 0;
    @(posedge clk); #1;
    reset = 1;
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 8;
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 4;
    e.err = 0; e.chk_rd = 1;
    e.port = 0; e.rd = 32'h88; sbq.push_back(e);
    e.port = 1; e.rd = 32'd161; sbq.push_back(e);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("post_ack0_c%0d", c), {31'd0, bus.ack0}, {31'd0, c == 2});
      chk($sformatf("post_ack1_c%0d", c), {31'd0, bus.ack1}, {31'd0, c == 5});
    end
    @(posedge clk); #1;
    bus.req0 = 0; bus.req1 = 0;
    // Saturation with 2-bit counters: 1,2,3,3.
    for (int k = 0; k < 4; k++) begin
      int n;
      @(posedge clk); #1;
      bus2.req1 = 1;
      n = 0;
      do begin @(negedge clk); n++; end while (!bus2.ack1 && n < 10);
      chk("sat_latency", n, 3);
      @(posedge clk); #1;
      bus2.req1 = 0;
      @(negedge clk);
      chk($sformatf("sat_cnt1_%0d", k), {30'd0, sc1}, k < 3 ? k + 1 : 3);
    end
    chk("sat_cnt0", {30'd0, sc0}, 0);
    chk("sb_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory (64 x 32-bit, synchronous write on posedge, combinational read) between two requesters.
- Port 0 is the CPU load/store path; port 1 is the program-loader/debug path.
- Grants one access at a time with round-robin arbitration and a registered request/acknowledge handshake.
- Range-checks addresses and keeps saturating per-port service counters.

Parameters:
- DATA_W, 32, data and address width.
- DEPTH, 64, number of memory words; legal word addresses are 0..DEPTH-1.
- CNT_W, 16, width of each per-port service counter.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req0  in  1  port 0 (CPU) request; held high with its fields stable until ack0.
- we0  in  1  port 0 write enable (1 = store, 0 = load).
- addr0  in  DATA_W  port 0 word address.
- wd0  in  DATA_W  port 0 write data.
- ack0  out  1  port 0 one-cycle completion pulse.
- rdata0  out  DATA_W  port 0 read data; valid only while ack0=1.
- req1, we1, addr1, wd1, ack1, rdata1: same as port 0, for port 1.
- err  out  1  one-cycle pulse with the ack of an out-of-range access.
- busy  out  1  high whenever state != IDLE; also used to stall the PC enable.
- mem_we  out  1  to memory write enable.
- mem_a  out  DATA_W  to memory address.
- mem_wd  out  DATA_W  to memory write data.
- mem_rd  in  DATA_W  from memory read data (combinational).
- cnt0, cnt1  out  CNT_W  completed accesses per port, saturating.

Behaviour:
- Reset (reset=0, asynchronous) sets:
  - state=IDLE, last_grant=1, so port 0 wins the first tie.
  - ack0=ack1=err=0, mem_we=0, mem_a=mem_wd=0.
  - rdata0=rdata1=0, cnt0=cnt1=0, busy=0.
  - Any latched request is discarded; no ack is issued for it.
- FSM: IDLE -> ACCESS -> RESP -> IDLE. Each access takes exactly 3 cycles, from the IDLE cycle where the request is sampled to the ack cycle.
- IDLE:
  - With no request, stay in IDLE.
  - With exactly one of req0/req1 high, grant that port.
  - With both high, grant the port != last_grant.
  - On grant, latch gid, we, addr, wd into internal registers; update last_grant=gid; go to ACCESS.
- ACCESS:
  - Drive mem_a=latched addr and mem_wd=latched wd.
  - mem_we=latched we AND in_range, where in_range = (addr < DEPTH); the memory writes at the end of this cycle.
  - Capture mem_rd into rdata_q (0 if out of range); go to RESP.
  - mem_we is 0 in every other state.
- RESP:
  - Pulse ack[gid]=1 for this cycle only; rdata[gid]=rdata_q.
  - The other port's ack=0 and its rdata holds its previous value.
  - err=!in_range; increment cnt[gid] unless it is already all-ones.
  - Go to IDLE.
- Store ack: rdata on a store ack is the pre-write word. The read in ACCESS occurs before the posedge write.
- Back-to-back requests: a requester may keep req high after ack to issue its next access. It is re-arbitrated in the following IDLE cycle, so with both ports requesting continuously, grants alternate 0,1,0,1.
- Request withdrawn before ack: protocol violation, but the latched access still completes and acks. Inputs are ignored outside IDLE.
- Out-of-range access: no memory write; rdata=0; err pulses with the ack. The counter still increments.
- Counter saturation: at all-ones, the counter holds its value.
- Reset asserted mid-ACCESS: mem_we drops immediately (asynchronous), so no write commits at the next edge.

Test Plan:
- Single write: port 0 store, addr0=4, wd0=161 at cycle 0 -> mem_we=1 in cycle 1; ack0 in cycle 2; a subsequent port 1 load of addr 4 returns rdata1=161; cnt0=1.
- Simultaneous requests: req0=req1=1 from reset, held continuously -> grant order 0,1,0,1; ack0 in cycles 2 and 8, ack1 in cycles 5 and 11; ack0 and ack1 never high together.
- Out-of-range: port 1 store, addr1=64, wd1=0xDEADBEEF -> mem_we stays 0; err=1 and ack1=1 in the same cycle; rdata1=0; memory word 0 is unchanged.
- Read-before-write: memory word 3 holds 90; port 0 store of 3 to addr 3 -> rdata0 at ack=90; a following load of addr 3 returns 3.
- Reset mid-access: reset=0 during ACCESS of a store to addr 8 -> no write, no ack; all outputs zero; after release, the first tie is granted to port 0.
- Saturation: preload cnt1 to 0xFFFE (force or via CNT_W=2 build) and issue two port 1 accesses -> cnt1 reads 0xFFFF after both; a third access leaves it at 0xFFFF.
